// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared state encodings and default parameters for the vending controller
package vend_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ACCUM    = 3'd1,
      ST_READY    = 3'd2,
      ST_DISPENSE = 3'd3,
      ST_CHANGE   = 3'd4
   } vend_state_t;

   localparam int VEND_CREDIT_W    = 8;
   localparam int VEND_COIN_A_VAL  = 50;
   localparam int VEND_COIN_B_VAL  = 100;
   localparam int VEND_PRICE       = 200;
   localparam int VEND_MAX_CREDIT  = 250;
   localparam int VEND_CHANGE_UNIT = 50;

   function automatic logic is_busy(input vend_state_t s);
      return (s == ST_DISPENSE) || (s == ST_CHANGE);
   endfunction

endpackage

// File: rtl/rise_pulse.sv
// rtl/rise_pulse.sv - registered rising-edge detector, one-cycle pulse per low-to-high input transition
module rise_pulse (
   input  logic clk,
   input  logic rst,
   input  logic i,
   output logic o
);

   logic prev;

   // prev clears in reset so an input held high across release still yields one pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev <= 1'b0;
         o    <= 1'b0;
      end else begin
         prev <= i;
         o    <= i & ~prev;
      end
   end

endmodule

// File: rtl/vending_controller.sv
// rtl/vending_controller.sv - coin-accepting vending FSM with credit, dispense and change payout
module vending_controller
   import vend_pkg::*;
#(
   parameter int CREDIT_W    = VEND_CREDIT_W,
   parameter int COIN_A_VAL  = VEND_COIN_A_VAL,
   parameter int COIN_B_VAL  = VEND_COIN_B_VAL,
   parameter int PRICE       = VEND_PRICE,
   parameter int MAX_CREDIT  = VEND_MAX_CREDIT,
   parameter int CHANGE_UNIT = VEND_CHANGE_UNIT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                coin_a,
   input  logic                coin_b,
   input  logic                vend,
   input  logic                cancel,
   output logic [2:0]          state,
   output logic [CREDIT_W-1:0] credit,
   output logic                dispense,
   output logic                change_pulse,
   output logic                reject,
   output logic                busy
);

   if (MAX_CREDIT >= (2 ** CREDIT_W) || PRICE > MAX_CREDIT ||
       CHANGE_UNIT <= 0 || COIN_A_VAL <= 0 || COIN_B_VAL <= 0 || PRICE <= 0 || MAX_CREDIT <= 0 ||
       (COIN_A_VAL % CHANGE_UNIT) != 0 || (COIN_B_VAL % CHANGE_UNIT) != 0 ||
       (PRICE % CHANGE_UNIT) != 0 || (MAX_CREDIT % CHANGE_UNIT) != 0) begin : g_bad_cfg
      $error("vending_controller: inconsistent credit parameters");
   end

   localparam logic [CREDIT_W:0]   A_V    = (CREDIT_W+1)'(COIN_A_VAL);
   localparam logic [CREDIT_W:0]   B_V    = (CREDIT_W+1)'(COIN_B_VAL);
   localparam logic [CREDIT_W:0]   MAX_V  = (CREDIT_W+1)'(MAX_CREDIT);
   localparam logic [CREDIT_W-1:0] PRICE_V = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W-1:0] UNIT_V  = CREDIT_W'(CHANGE_UNIT);
   localparam logic [CREDIT_W-1:0] ZERO_V  = '0;

   logic coin_a_p, coin_b_p, vend_p, cancel_p;

   rise_pulse u_rise_coin_a (.clk(clk), .rst(rst), .i(coin_a), .o(coin_a_p));
   rise_pulse u_rise_coin_b (.clk(clk), .rst(rst), .i(coin_b), .o(coin_b_p));
   rise_pulse u_rise_vend   (.clk(clk), .rst(rst), .i(vend),   .o(vend_p));
   rise_pulse u_rise_cancel (.clk(clk), .rst(rst), .i(cancel), .o(cancel_p));

   vend_state_t         state_q, state_nxt;
   logic [CREDIT_W-1:0] credit_q, credit_nxt;
   logic [CREDIT_W:0]   sum_a, sum_b;
   logic                reject_nxt, dispense_nxt, change_nxt, busy_nxt;

   assign sum_a = {1'b0, credit_q} + A_V;
   assign sum_b = {1'b0, credit_q} + B_V;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         credit_q     <= '0;
         dispense     <= 1'b0;
         change_pulse <= 1'b0;
         reject       <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state_q      <= state_nxt;
         credit_q     <= credit_nxt;
         dispense     <= dispense_nxt;
         change_pulse <= change_nxt;
         reject       <= reject_nxt;
         busy         <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt  = state_q;
      credit_nxt = credit_q;
      reject_nxt = 1'b0;
      case (state_q)
         ST_IDLE, ST_ACCUM: begin
            // a coin swallowed by a winning cancel is still reported as refused
            if (cancel_p && state_q == ST_ACCUM) begin
               state_nxt  = ST_CHANGE;
               reject_nxt = coin_a_p | coin_b_p;
            end else if (coin_a_p || coin_b_p) begin
               if (coin_a_p) begin
                  if (sum_a <= MAX_V) credit_nxt = sum_a[CREDIT_W-1:0];
                  else                reject_nxt = 1'b1;
                  if (coin_b_p)       reject_nxt = 1'b1;
               end else begin
                  if (sum_b <= MAX_V) credit_nxt = sum_b[CREDIT_W-1:0];
                  else                reject_nxt = 1'b1;
               end
               if (credit_nxt >= PRICE_V)    state_nxt = ST_READY;
               else if (credit_nxt != ZERO_V) state_nxt = ST_ACCUM;
               else                          state_nxt = ST_IDLE;
            end
         end
         ST_READY: begin
            reject_nxt = coin_a_p | coin_b_p;
            if (cancel_p) begin
               state_nxt = ST_CHANGE;
            end else if (vend_p) begin
               state_nxt  = ST_DISPENSE;
               credit_nxt = credit_q - PRICE_V;
            end
         end
         ST_DISPENSE: begin
            reject_nxt = coin_a_p | coin_b_p;
            state_nxt  = (credit_q != ZERO_V) ? ST_CHANGE : ST_IDLE;
         end
         ST_CHANGE: begin
            reject_nxt = coin_a_p | coin_b_p;
            if (credit_q >= UNIT_V) begin
               credit_nxt = credit_q - UNIT_V;
               state_nxt  = (credit_nxt == ZERO_V) ? ST_IDLE : ST_CHANGE;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt  = ST_IDLE;
            credit_nxt = '0;
         end
      endcase
   end

   // outputs are registered from next-state values so they line up with the state they describe
   always_comb begin
      dispense_nxt = (state_nxt == ST_DISPENSE);
      change_nxt   = (state_nxt == ST_CHANGE) && (credit_nxt >= UNIT_V);
      busy_nxt     = is_busy(state_nxt);
   end

   assign state  = state_q;
   assign credit = credit_q;

endmodule
